// File: rtl/alu_seq_if.sv
// Request/response bus for the sequential ALU: operands, operation select,
// start strobe, and the registered status/result returned by the block.
interface alu_seq_if #(
   parameter int N = 4
);
   logic [N-1:0]   A;
   logic [N-1:0]   B;
   logic [2:0]     Function;
   logic           Start;
   logic           Busy;
   logic           Done;
   logic [2*N-1:0] ALUOut;

   modport master (
      output A, B, Function, Start,
      input  Busy, Done, ALUOut
   );

   modport slave (
      input  A, B, Function, Start,
      output Busy, Done, ALUOut
   );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU. Single-cycle operations write ALUOut at the accepting edge.
// Multiply runs an N-cycle shift-add loop in the MUL state and updates ALUOut
// only on its final iteration, so the partial sum never appears on the bus.
module alu_seq #(
   parameter int N = 4
) (
   input  logic     Clock,
   input  logic     Resetn,
   alu_seq_if.slave bus
);
   localparam int CW = $clog2(N + 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_MUL  = 1'b1;

   localparam logic [2:0] F_ADD  = 3'b000;
   localparam logic [2:0] F_ROR  = 3'b001;
   localparam logic [2:0] F_RAND = 3'b010;
   localparam logic [2:0] F_CAT  = 3'b011;
   localparam logic [2:0] F_MUL  = 3'b100;
   localparam logic [2:0] F_ACC  = 3'b101;
   localparam logic [2:0] F_CLR  = 3'b110;

   logic [0:0]     r_state;
   logic           r_busy;
   logic           r_done;
   logic [2*N-1:0] r_out;
   logic [2*N-1:0] r_mcand;   // captured A, shifted left once per iteration
   logic [N-1:0]   r_mplier;  // captured B, shifted right once per iteration
   logic [2*N-1:0] r_acc;     // running partial product
   logic [CW-1:0]  r_cnt;

   logic           w_accept;
   logic           w_is_mul;
   logic           w_last;
   logic [2*N-1:0] w_res;
   logic [2*N-1:0] w_acc_nxt;

   // A request is only taken while idle; Start during a multiply is dropped.
   assign w_accept  = bus.Start && (r_state == S_IDLE);
   assign w_is_mul  = (bus.Function == F_MUL);
   assign w_last    = (r_cnt == CW'(N - 1));
   assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

   assign bus.Busy   = r_busy;
   assign bus.Done   = r_done;
   assign bus.ALUOut = r_out;

   // Result of a single-cycle operation, formed from the operands being accepted.
   always_comb begin
      w_res = r_out;
      case (bus.Function)
         F_ADD:   w_res = {{N{1'b0}}, bus.A} + {{N{1'b0}}, bus.B};
         F_ROR:   w_res = {{(2*N-1){1'b0}}, |{bus.A, bus.B}};
         F_RAND:  w_res = {{(2*N-1){1'b0}}, &{bus.A, bus.B}};
         F_CAT:   w_res = {bus.A, bus.B};
         F_ACC:   w_res = r_out + {{N{1'b0}}, bus.A};
         F_CLR:   w_res = '0;
         default: w_res = r_out;   // no-op holds; multiply never uses this path
      endcase
   end

   // Control FSM: state, Busy, Done pulse and iteration counter.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (w_is_mul) begin
                     r_state <= S_MUL;
                     r_busy  <= 1'b1;
                     r_cnt   <= '0;
                  end else begin
                     r_done  <= 1'b1;
                  end
               end
            end
            default: begin
               if (w_last) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_cnt   <= r_cnt + CW'(1);
               end
            end
         endcase
      end
   end

   // Datapath: operand capture, shift-add iteration and result register.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         r_out    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
      end else begin
         if (r_state == S_IDLE) begin
            if (w_accept) begin
               if (w_is_mul) begin
                  r_mcand  <= {{N{1'b0}}, bus.A};
                  r_mplier <= bus.B;
                  r_acc    <= '0;
               end else begin
                  r_out    <= w_res;
               end
            end
         end else begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (w_last) begin
               r_out <= w_acc_nxt;
            end
         end
      end
   end
endmodule
